// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux-select arbiter.
package mux_sel_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Channel indices as seen on the downstream 4:1 mux select.
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  // One-hot decode of a channel index.
  function automatic logic [3:0] ch_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = '0;
    case (idx)
      CH_A:    oh = 4'b0001;
      CH_B:    oh = 4'b0010;
      CH_C:    oh = 4'b0100;
      CH_D:    oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// Combinational 4-way rotating-priority picker: returns the first set
// request scanning ptr, ptr+1, ... (mod 4). Reusable by other arbiters.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  // Scan the four candidates in rotated order; first hit wins.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter producing the 2-bit select for a downstream 4:1 mux.
// One owner at a time, held until done, request drop or hold timeout,
// with a single idle bubble between owners.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        sel_nxt;
  logic              valid_nxt;
  logic              timeout_nxt;
  logic [1:0]        ptr;
  logic [1:0]        ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [1:0]        pick_idx;
  logic              pick_any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State, select, pointer and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= CH_A;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= CH_A;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      valid    <= valid_nxt;
      timeout  <= timeout_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic: grant from IDLE, release from OWN with done/drop
  // taking priority over the forced hold-limit release.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    valid_nxt   = valid;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = OWN;
          sel_nxt   = pick_idx;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      OWN: begin
        if (done || !req[sel]) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          ptr_nxt   = sel + 2'd1;
        end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b0;
          timeout_nxt = 1'b1;
          ptr_nxt     = sel + 2'd1;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Grant is a pure decode of registered state.
  always_comb begin
    grant = valid ? ch_onehot(sel) : '0;
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed scenarios plus
// randomized traffic, all compared against a cycle-level ownership model.
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  int checks;
  int errors;

  // Reference model: who owns the mux, for how many cycles, and where the
  // round-robin scan starts next.
  int         m_owner;   // -1 = nobody
  int         m_ptr;
  int         m_held;    // cycles with valid=1 so far for current owner
  logic [1:0] m_sel;
  logic       m_tout;

  mux_sel_arbiter #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 2'd0;
    m_tout  = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int c;
    if (m_owner < 0) begin
      m_tout = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_sel   = 2'(c);
          m_held  = 1;
        end
      end
    end else if (d || !r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_tout  = 1'b0;
    end else if (m_held == MAX_HOLD) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_tout  = 1'b1;
    end else begin
      m_held++;
      m_tout = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic       ev;
    logic [3:0] eg;
    ev = (m_owner >= 0);
    eg = ev ? (4'b0001 << m_sel) : 4'b0000;
    checks++;
    assert (valid === ev) else begin
      errors++;
      $error("FAIL %s valid got %0b exp %0b", tag, valid, ev);
    end
    checks++;
    assert (sel === m_sel) else begin
      errors++;
      $error("FAIL %s sel got %0d exp %0d", tag, sel, m_sel);
    end
    checks++;
    assert (grant === eg) else begin
      errors++;
      $error("FAIL %s grant got %b exp %b", tag, grant, eg);
    end
    checks++;
    assert (timeout === m_tout) else begin
      errors++;
      $error("FAIL %s timeout got %0b exp %0b", tag, timeout, m_tout);
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, check 1 ns later.
  task automatic cyc(input logic [3:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    done  = 1'b0;
    rst_n = 1'b0;
    #3;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_exp[5];
    int vcnt;
    logic [3:0] r;
    logic d;
    checks = 0;
    errors = 0;
    rr_exp = '{0, 1, 2, 3, 0};
    rst_n = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();

    do_reset();

    // Latency: single request from IDLE granted on the next edge.
    cyc(4'b0100, 1'b0, "lat_grant");
    checks++;
    assert (valid === 1'b1 && sel === 2'd2 && grant === 4'b0100) else begin
      errors++;
      $error("FAIL lat_grant_direct valid/sel/grant got %0b/%0d/%b exp 1/2/0100", valid, sel, grant);
    end
    cyc(4'b0100, 1'b1, "lat_done");
    checks++;
    assert (valid === 1'b0 && sel === 2'd2) else begin
      errors++;
      $error("FAIL lat_release valid/sel got %0b/%0d exp 0/2", valid, sel);
    end

    // Async reset mid-ownership with sel=2.
    cyc(4'b0100, 1'b0, "pre_rst_grant");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    assert (valid === 1'b0 && grant === 4'b0000 && sel === 2'd0 && timeout === 1'b0) else begin
      errors++;
      $error("FAIL async_reset valid/grant/sel/timeout got %0b/%b/%0d/%0b exp 0/0000/0/0", valid, grant, sel, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with all channels requesting, done after 2 cycles.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 1'b0, "rr_grant");
      checks++;
      assert (valid === 1'b1 && sel === 2'(rr_exp[g])) else begin
        errors++;
        $error("FAIL rr_owner valid/sel got %0b/%0d exp 1/%0d", valid, sel, rr_exp[g]);
      end
      cyc(4'b1111, 1'b0, "rr_hold");
      cyc(4'b1111, 1'b1, "rr_release");
      checks++;
      assert (valid === 1'b0) else begin
        errors++;
        $error("FAIL rr_bubble valid got %0b exp 0", valid);
      end
    end

    // Hold timeout: ch0 alone, never done.
    do_reset();
    vcnt = 0;
    cyc(4'b0001, 1'b0, "to_grant");
    while (valid === 1'b1 && vcnt < 40) begin
      vcnt++;
      cyc(4'b0001, 1'b0, "to_hold");
    end
    checks++;
    assert (vcnt == 16) else begin
      errors++;
      $error("FAIL to_valid_len got %0d exp 16", vcnt);
    end
    checks++;
    assert (timeout === 1'b1 && valid === 1'b0) else begin
      errors++;
      $error("FAIL to_pulse timeout/valid got %0b/%0b exp 1/0", timeout, valid);
    end
    cyc(4'b0011, 1'b0, "to_next");
    checks++;
    assert (timeout === 1'b0 && valid === 1'b1 && sel === 2'd1) else begin
      errors++;
      $error("FAIL to_ptr timeout/valid/sel got %0b/%0b/%0d exp 0/1/1", timeout, valid, sel);
    end
    cyc(4'b0011, 1'b1, "to_next_rel");

    // Collision: done on the last allowed hold cycle wins over timeout.
    do_reset();
    cyc(4'b0001, 1'b0, "col_grant");
    for (int i = 0; i < 15; i++) cyc(4'b0001, 1'b0, "col_hold");
    cyc(4'b0001, 1'b1, "col_done");
    checks++;
    assert (valid === 1'b0 && timeout === 1'b0) else begin
      errors++;
      $error("FAIL collision valid/timeout got %0b/%0b exp 0/0", valid, timeout);
    end

    // Request drop by owner 3, pointer wraps to 0.
    do_reset();
    cyc(4'b1000, 1'b0, "drop_grant");
    cyc(4'b1000, 1'b0, "drop_hold");
    cyc(4'b0001, 1'b0, "drop_release");
    checks++;
    assert (valid === 1'b0 && sel === 2'd3 && timeout === 1'b0) else begin
      errors++;
      $error("FAIL drop_release valid/sel/timeout got %0b/%0d/%0b exp 0/3/0", valid, sel, timeout);
    end
    cyc(4'b1001, 1'b0, "wrap_grant");
    checks++;
    assert (valid === 1'b1 && sel === 2'd0) else begin
      errors++;
      $error("FAIL wrap_grant valid/sel got %0b/%0d exp 1/0", valid, sel);
    end

    // Randomized traffic: sticky requests so holds can run to timeout.
    r = 4'(($urandom_range(0, 15)));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 7) == 0);
      cyc(r, d, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
